guess_responder: RTL
====================

// Module: guess_responder
// PURPOSE
//  Responder end of the CM guess protocol: FPGA-side model of the MCU password checker.
//  Generates CLK_inter and announces BEGIN_GUESSING, then receives framed guesses
//  START, CODE_LEN bytes, END. Compares byte-by-byte with intentional early exit, so
//  reply latency leaks the matching-prefix length, then replies YES/NO on CM.
//  Serves as a timing-attack target/loopback partner for the guessing initiator.
// PARAMETERS
//  CODE_LEN     2           number of secret bytes
//  SECRET       16'h3CA5    secret, byte i = SECRET[8*i+:8]; every byte must be in 0x06..0xFF
//  CLK_DIV      25          CLK_50 cycles per CLK_inter half-period (min 1)
//  CMP_TICKS    16          rise ticks spent per compared byte (min 1)
//  BEGIN_TICKS  4           rise ticks BEGIN_GUESSING is held on CM
//  REPLY_TICKS  4           rise ticks YES/NO is held on CM
// PORTS
//  CLK_50     in     1  system clock; all logic on posedge
//  SW         in     1  SW[0] = reset: synchronous, active-high
//  CLK_inter  out    1  registered interconnect clock driven by this block
//  CM         inout  8  shared bus; driven only in ANNOUNCE/REPLY, else 8'hzz
//  LED        out    8  {last_result_yes, attempts[6:0]}
// BEHAVIOUR
//  Reset: CLK_inter=0, CM released, LED=0, divider=0, all counters=0, state=ANNOUNCE.
//   Asserting reset mid-frame/mid-compare/mid-reply aborts; bus released the next cycle.
//  Divider: counter 0..CLK_DIV-1; on wrap CLK_inter toggles. rise_tick/fall_tick are
//   1-cycle pulses in the cycle CLK_inter goes 0->1 / 1->0.
//  CM is sampled only on rise_tick. Drive enable and drive value change only on fall_tick.
//   The initiator therefore sees stable data at each rise.
//  States:
//   ANNOUNCE: drive 8'h02. At the first fall_tick after reset, enable; tick_cnt counts
//    rise_ticks; at BEGIN_TICKS release on the next fall_tick -> LISTEN.
//   LISTEN: sample each rise_tick; 8'h01 -> RECV (idx=0); any other value is ignored.
//   RECV: guess[idx] <= CM each rise_tick. At idx==CODE_LEN-1 -> CHK_END.
//   CHK_END: next rise sample == 8'h05 -> COMPARE (i=0, tick_cnt=0).
//    Any other value is a framing error: -> LISTEN, no reply, attempts unchanged.
//   COMPARE: after CMP_TICKS rise_ticks, evaluate guess[i] vs secret[i].
//    Mismatch -> result=NO -> REPLY.
//    Match and i==CODE_LEN-1 -> result=YES -> REPLY.
//    Otherwise i++ and repeat.
//    Compare time is (k+1)*CMP_TICKS ticks, k = matching prefix length, capped at CODE_LEN.
//   REPLY: at next fall_tick drive 8'h03 (YES) or 8'h04 (NO); hold REPLY_TICKS rise_ticks;
//    release at the following fall_tick. attempts += 1, saturating at 127.
//    last_result_yes updated; -> LISTEN.
//  Bytes arriving during COMPARE/REPLY are ignored; no queueing.
//  guess bytes are unconstrained (0x00..0xFF); only the compare reads them.
//  Width rules: tick_cnt wide enough for max(CMP_TICKS,BEGIN_TICKS,REPLY_TICKS);
//   idx/i use $clog2(CODE_LEN), min 1 bit. The divider never skips or stalls.
// STRUCTURE
//  Package cm_proto_pkg, shared with the initiator side:
//   START_BYTE=01, BEGIN_GUESSING=02, YES=03, NO=04, END_BYTE=05, START_GUESS_RANGE=06.
//   Also holds the responder state enum typedef.
//  Sub-module clk_inter_gen (CLK_DIV): registered CLK_inter plus rise_tick/fall_tick.
//  Top holds the FSM, guess register array, and tristate (CM = oe ? dout : 'z).
// TESTING (CODE_LEN=2, SECRET=16'h3CA5, CLK_DIV=2, CMP_TICKS=4, BEGIN/REPLY_TICKS=2)
//  Release reset -> CM==02 for exactly 2 rise samples, then zz; CLK_inter period 4 cycles.
//  Frame 01,11,22,05 -> CM==04 from the 1st fall after 4 compare ticks; LED==8'h01.
//  Frame 01,A5,22,05 -> NO after 8 compare ticks; latency exactly 4 ticks more than above.
//  Frame 01,A5,3C,05 -> CM==03 after 8 compare ticks; LED==8'h81 (after two prior attempts: 8'h83).
//  Frame 01,A5,3C,07 -> no drive on CM, LED unchanged; then 00,01,A5,3C,05 -> YES.
//  Reset during COMPARE, then during REPLY -> CM==zz next cycle; ANNOUNCE restarts; LED==0.

Source files
------------

// File: rtl/cm_proto_pkg.sv
// CM guess protocol constants and responder state type.
// Shared by the initiator and responder ends.
package cm_proto_pkg;

    localparam logic [7:0] START_BYTE        = 8'h01;
    localparam logic [7:0] BEGIN_GUESSING    = 8'h02;
    localparam logic [7:0] YES               = 8'h03;
    localparam logic [7:0] NO                = 8'h04;
    localparam logic [7:0] END_BYTE          = 8'h05;
    localparam logic [7:0] START_GUESS_RANGE = 8'h06;

    typedef enum logic [2:0] {
        ST_ANNOUNCE,
        ST_LISTEN,
        ST_RECV,
        ST_CHK_END,
        ST_COMPARE,
        ST_REPLY
    } resp_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_inter_gen.sv
// Interconnect clock divider: registered CLK_inter plus single-cycle
// rise/fall pulses that coincide with the cycle CLK_inter changes level.
module clk_inter_gen
    import cm_proto_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic clk_inter_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int unsigned     DIV_W    = clog2_min1(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             clk_inter_q, clk_inter_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             wrap_c;

    always_comb begin
        wrap_c      = (div_q == DIV_LAST);
        div_d       = wrap_c ? '0 : div_q + DIV_W'(1);
        clk_inter_d = wrap_c ? ~clk_inter_q : clk_inter_q;
        rise_d      = wrap_c & ~clk_inter_q;
        fall_d      = wrap_c & clk_inter_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q       <= '0;
            clk_inter_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            div_q       <= div_d;
            clk_inter_q <= clk_inter_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
        end
    end

    assign clk_inter_o = clk_inter_q;
    assign rise_tick_o = rise_q;
    assign fall_tick_o = fall_q;

endmodule

// File: rtl/guess_responder.sv
// Responder end of the CM guess protocol: announces, receives framed guesses,
// compares with early exit (latency leaks prefix length) and replies YES/NO.
module guess_responder
    import cm_proto_pkg::*;
#(
    parameter int unsigned              CODE_LEN    = 2,
    parameter logic [8*CODE_LEN-1:0]    SECRET      = 16'h3CA5,
    parameter int unsigned              CLK_DIV     = 25,
    parameter int unsigned              CMP_TICKS   = 16,
    parameter int unsigned              BEGIN_TICKS = 4,
    parameter int unsigned              REPLY_TICKS = 4
) (
    input  logic       CLK_50,
    input  logic [0:0] SW,
    output logic       CLK_inter,
    inout  wire  [7:0] CM,
    output logic [7:0] LED
);

    localparam int unsigned      TICK_W   = clog2_min1(max3(CMP_TICKS, BEGIN_TICKS, REPLY_TICKS) + 1);
    localparam int unsigned      IDX_W    = clog2_min1(CODE_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_LEN - 1);
    localparam logic [TICK_W-1:0] BEGIN_T = TICK_W'(BEGIN_TICKS);
    localparam logic [TICK_W-1:0] REPLY_T = TICK_W'(REPLY_TICKS);
    localparam logic [TICK_W-1:0] CMP_T   = TICK_W'(CMP_TICKS - 1);

    logic rst;
    logic rise_tick;
    logic fall_tick;

    resp_state_e       state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        guess_q [CODE_LEN];
    logic [7:0]        guess_d [CODE_LEN];
    logic              oe_q, oe_d;
    logic [7:0]        dout_q, dout_d;
    logic              yes_q, yes_d;
    logic [6:0]        attempts_q, attempts_d;
    logic              last_yes_q, last_yes_d;

    logic [7:0]        secret_b [CODE_LEN];
    logic [7:0]        cm_c;
    logic              cmp_done_c;
    logic              byte_match_c;

    assign rst = SW[0];

    clk_inter_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk_i       (CLK_50),
        .rst_i       (rst),
        .clk_inter_o (CLK_inter),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick)
    );

    for (genvar g = 0; g < CODE_LEN; g++) begin : g_secret
        assign secret_b[g] = SECRET[8*g +: 8];
    end

    assign cm_c         = CM;
    assign cmp_done_c   = (tick_q == CMP_T);
    assign byte_match_c = (guess_q[idx_q] == secret_b[idx_q]);

    always_ff @(posedge CLK_50) begin
        if (rst) begin
            state_q    <= ST_ANNOUNCE;
            tick_q     <= '0;
            idx_q      <= '0;
            guess_q    <= '{default: 8'h00};
            oe_q       <= 1'b0;
            dout_q     <= 8'h00;
            yes_q      <= 1'b0;
            attempts_q <= '0;
            last_yes_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            idx_q      <= idx_d;
            guess_q    <= guess_d;
            oe_q       <= oe_d;
            dout_q     <= dout_d;
            yes_q      <= yes_d;
            attempts_q <= attempts_d;
            last_yes_q <= last_yes_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ANNOUNCE: if (oe_q && fall_tick && tick_q == BEGIN_T) state_d = ST_LISTEN;
            ST_LISTEN:   if (rise_tick && cm_c == START_BYTE) state_d = ST_RECV;
            ST_RECV:     if (rise_tick && idx_q == IDX_LAST) state_d = ST_CHK_END;
            ST_CHK_END:  if (rise_tick) state_d = (cm_c == END_BYTE) ? ST_COMPARE : ST_LISTEN;
            ST_COMPARE:  if (rise_tick && cmp_done_c && (!byte_match_c || idx_q == IDX_LAST))
                             state_d = ST_REPLY;
            ST_REPLY:    if (oe_q && fall_tick && tick_q == REPLY_T) state_d = ST_LISTEN;
            default:     state_d = ST_ANNOUNCE;
        endcase
    end

    // Bus enable/value only move on fall ticks so the initiator samples stable data.
    always_comb begin
        tick_d     = tick_q;
        idx_d      = idx_q;
        guess_d    = guess_q;
        oe_d       = oe_q;
        dout_d     = dout_q;
        yes_d      = yes_q;
        attempts_d = attempts_q;
        last_yes_d = last_yes_q;
        unique case (state_q)
            ST_ANNOUNCE: begin
                if (!oe_q && fall_tick) begin
                    oe_d   = 1'b1;
                    dout_d = BEGIN_GUESSING;
                end else if (oe_q && rise_tick) begin
                    tick_d = tick_q + TICK_W'(1);
                end else if (oe_q && fall_tick && tick_q == BEGIN_T) begin
                    oe_d   = 1'b0;
                    tick_d = '0;
                end
            end
            ST_LISTEN: begin
                if (rise_tick && cm_c == START_BYTE) idx_d = '0;
            end
            ST_RECV: begin
                if (rise_tick) begin
                    guess_d[idx_q] = cm_c;
                    if (idx_q != IDX_LAST) idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_CHK_END: begin
                if (rise_tick) begin
                    idx_d  = '0;
                    tick_d = '0;
                end
            end
            ST_COMPARE: begin
                // Early exit on the first mismatching byte is the intended timing leak.
                if (rise_tick) begin
                    if (cmp_done_c) begin
                        tick_d = '0;
                        if (!byte_match_c)          yes_d = 1'b0;
                        else if (idx_q == IDX_LAST) yes_d = 1'b1;
                        else                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            ST_REPLY: begin
                if (!oe_q && fall_tick) begin
                    oe_d   = 1'b1;
                    dout_d = yes_q ? YES : NO;
                end else if (oe_q && rise_tick) begin
                    tick_d = tick_q + TICK_W'(1);
                end else if (oe_q && fall_tick && tick_q == REPLY_T) begin
                    oe_d       = 1'b0;
                    tick_d     = '0;
                    last_yes_d = yes_q;
                    if (attempts_q != 7'h7F) attempts_d = attempts_q + 7'd1;
                end
            end
            default: begin
                oe_d = 1'b0;
            end
        endcase
    end

    assign CM  = oe_q ? dout_q : 8'hzz;
    assign LED = {last_yes_q, attempts_q};

endmodule
